// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: the sequencer states, default widths
// and the ALU opcode that routes an instruction to the iterative MOD unit.
package core_sequencer_pkg;

    localparam int DEF_PC_W     = 10;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_MAX_WAIT = 64;
    localparam int ALU_OP_W     = 5;

    localparam logic [ALU_OP_W-1:0] ALU_MOD = 5'd13;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM_WAIT,
        MOD_WAIT,
        HALTED,
        FAULT
    } seq_state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Bundle between the sequencer and its surroundings: decode flags and strobes in,
// PC, control strobes and harness status out.
interface core_sequencer_if
    import core_sequencer_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic                start;
    logic [PC_W-1:0]     start_addr;
    logic                halt;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic                branch_taken;
    logic [PC_W-1:0]     branch_target;
    logic                mem_ready;
    logic                mod_done;

    logic [PC_W-1:0]     pc;
    logic                ir_load;
    logic                mem_req;
    logic                mod_start;
    logic                commit;
    logic                done;
    logic                fault;
    logic [CNT_W-1:0]    cycle_count;

    modport master (
        input  start, start_addr, halt, branch, mem_read, mem_write, alu_op,
               branch_taken, branch_target, mem_ready, mod_done,
        output pc, ir_load, mem_req, mod_start, commit, done, fault, cycle_count
    );

    modport slave (
        output start, start_addr, halt, branch, mem_read, mem_write, alu_op,
               branch_taken, branch_target, mem_ready, mod_done,
        input  pc, ir_load, mem_req, mod_start, commit, done, fault, cycle_count
    );

endinterface

// File: rtl/core_sequencer_seq_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting on memory or the MOD unit and
// flags the last permitted wait cycle so the sequencer can fault if no strobe comes.
module seq_watchdog
    import core_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int CW = $clog2(MAX_WAIT) + 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CW'(MAX_WAIT))) begin
            r_count <= r_count + CW'(1);
        end
    end

    // High during the MAX_WAIT-th wait cycle; a strobe in that same cycle still wins.
    assign o_timeout = i_enable && (r_count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, steps instructions through
// fetch/execute/wait states and issues one commit pulse per retired instruction.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst_n,
    core_sequencer_if.master bus
);

    seq_state_t       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cycleCount;
    logic             r_irLoad;
    logic             r_memReq;
    logic             r_modStart;
    logic             r_done;
    logic             r_fault;

    logic             w_memOp;
    logic             w_isMod;
    logic             w_waiting;
    logic             w_counting;
    logic             w_timeout;
    logic             w_commit;
    logic [PC_W-1:0]  w_nextPc;

    assign w_memOp    = bus.mem_read | bus.mem_write;
    assign w_isMod    = (bus.alu_op == ALU_MOD);
    assign w_waiting  = (r_state == MEM_WAIT) || (r_state == MOD_WAIT);
    assign w_counting = (r_state == FETCH) || (r_state == EXEC) || w_waiting;

    // Commit depends on the decode of the instruction in flight, so it cannot be registered.
    assign w_commit = ((r_state == EXEC) && !bus.halt && !w_memOp && !w_isMod) ||
                      ((r_state == MEM_WAIT) && bus.mem_ready) ||
                      ((r_state == MOD_WAIT) && bus.mod_done);

    assign w_nextPc = (bus.branch && bus.branch_taken) ? bus.branch_target
                                                       : r_pc + PC_W'(1);

    seq_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state == EXEC),
        .i_enable  (w_waiting),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_cycleCount <= '0;
            r_irLoad     <= 1'b0;
            r_memReq     <= 1'b0;
            r_modStart   <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_irLoad   <= 1'b0;
            r_modStart <= 1'b0;

            if (w_counting && (r_cycleCount != '1)) begin
                r_cycleCount <= r_cycleCount + CNT_W'(1);
            end

            if (w_commit) begin
                r_pc <= w_nextPc;
            end

            case (r_state)
                IDLE, HALTED, FAULT: begin
                    if (bus.start) begin
                        r_pc         <= bus.start_addr;
                        r_cycleCount <= '0;
                        r_irLoad     <= 1'b1;
                        r_done       <= 1'b0;
                        r_fault      <= 1'b0;
                        r_state      <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (bus.halt) begin
                        r_done  <= 1'b1;
                        r_state <= HALTED;
                    end else if (w_memOp) begin
                        r_memReq <= 1'b1;
                        r_state  <= MEM_WAIT;
                    end else if (w_isMod) begin
                        r_modStart <= 1'b1;
                        r_state    <= MOD_WAIT;
                    end else begin
                        r_irLoad <= 1'b1;
                        r_state  <= FETCH;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        r_memReq <= 1'b0;
                        r_irLoad <= 1'b1;
                        r_state  <= FETCH;
                    end else if (w_timeout) begin
                        r_memReq <= 1'b0;
                        r_fault  <= 1'b1;
                        r_state  <= FAULT;
                    end
                end
                MOD_WAIT: begin
                    if (bus.mod_done) begin
                        r_irLoad <= 1'b1;
                        r_state  <= FETCH;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_state <= FAULT;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.ir_load     = r_irLoad;
    assign bus.mem_req     = r_memReq;
    assign bus.mod_start   = r_modStart;
    assign bus.commit      = w_commit;
    assign bus.done        = r_done;
    assign bus.fault       = r_fault;
    assign bus.cycle_count = r_cycleCount;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: an instruction-level timeline model sets the
// expected outputs for every cycle, and literal checks pin key results.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    localparam int TB_MAX  = DEF_MAX_WAIT;
    localparam int PC_MOD  = 1 << DEF_PC_W;
    localparam int CNT_MAX = (1 << DEF_CNT_W) - 1;

    typedef enum {K_ADD, K_BRANCH, K_HALT, K_LOAD, K_STORE, K_MOD} kind_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    int commitSeen = 0;
    int memReqSeen = 0;
    bit checkEn    = 1'b0;

    logic [DEF_PC_W-1:0]  expPc;
    logic [DEF_CNT_W-1:0] expCount;
    logic expIrLoad, expMemReq, expModStart, expCommit, expDone, expFault;

    int mPc    = 0;
    int mCount = 0;
    bit mDone  = 1'b0;
    bit mFault = 1'b0;

    always #5 clk = ~clk;

    core_sequencer_if bus ();

    core_sequencer #(
        .PC_W     (DEF_PC_W),
        .CNT_W    (DEF_CNT_W),
        .MAX_WAIT (TB_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, actual, required);
        end
    endtask

    // Every cycle the model is armed, all outputs are compared away from the rising edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("pc",        32'(bus.pc),          32'(expPc));
            checkOutput("count",     32'(bus.cycle_count), 32'(expCount));
            checkOutput("irLoad",    32'(bus.ir_load),     32'(expIrLoad));
            checkOutput("memReq",    32'(bus.mem_req),     32'(expMemReq));
            checkOutput("modStart",  32'(bus.mod_start),   32'(expModStart));
            checkOutput("commit",    32'(bus.commit),      32'(expCommit));
            checkOutput("done",      32'(bus.done),        32'(expDone));
            checkOutput("fault",     32'(bus.fault),       32'(expFault));
        end
        if (rst_n) begin
            if (bus.commit)  commitSeen++;
            if (bus.mem_req) memReqSeen++;
        end
    end

    function automatic void setExp(input bit ir, input bit mreq, input bit mst, input bit cmt);
        expPc       = DEF_PC_W'(mPc);
        expCount    = DEF_CNT_W'(mCount);
        expDone     = mDone;
        expFault    = mFault;
        expIrLoad   = ir;
        expMemReq   = mreq;
        expModStart = mst;
        expCommit   = cmt;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bumpCount();
        if (mCount < CNT_MAX) mCount++;
    endtask

    task automatic clearDecode();
        bus.start         = 1'b0;
        bus.halt          = 1'b0;
        bus.branch        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.alu_op        = 5'd0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.mem_ready     = 1'b0;
        bus.mod_done      = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "Pc"},       32'(bus.pc),          32'h0);
        checkOutput({tag, "Count"},    32'(bus.cycle_count), 32'h0);
        checkOutput({tag, "IrLoad"},   32'(bus.ir_load),     32'h0);
        checkOutput({tag, "MemReq"},   32'(bus.mem_req),     32'h0);
        checkOutput({tag, "ModStart"}, 32'(bus.mod_start),   32'h0);
        checkOutput({tag, "Commit"},   32'(bus.commit),      32'h0);
        checkOutput({tag, "Done"},     32'(bus.done),        32'h0);
        checkOutput({tag, "Fault"},    32'(bus.fault),       32'h0);
    endtask

    task automatic idleCycle();
        clearDecode();
        setExp(1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
    endtask

    task automatic startProgram(input int addr);
        clearDecode();
        bus.start      = 1'b1;
        bus.start_addr = DEF_PC_W'(addr);
        setExp(1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        bus.start = 1'b0;
        mPc    = addr;
        mCount = 0;
        mDone  = 1'b0;
        mFault = 1'b0;
    endtask

    // One instruction: FETCH, EXEC, then nWait silent wait cycles and a strobe cycle,
    // or MAX_WAIT silent cycles ending in a fault when strobe is 0.
    task automatic applyStimulus(input kind_t kind, input bit taken, input int target,
                                 input int nWait, input bit strobe, input bit startInExec,
                                 input int resetAt);
        bit isMem;
        bit isMod;
        bit cmt;
        bit hit;
        int last;
        clearDecode();
        setExp(1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        bumpCount();

        isMem = (kind == K_LOAD) || (kind == K_STORE);
        isMod = (kind == K_MOD);
        cmt   = (kind == K_ADD) || (kind == K_BRANCH);
        bus.halt          = (kind == K_HALT);
        bus.branch        = (kind == K_BRANCH);
        bus.branch_taken  = taken;
        bus.branch_target = DEF_PC_W'(target);
        bus.mem_read      = (kind == K_LOAD);
        bus.mem_write     = (kind == K_STORE);
        bus.alu_op        = isMod ? ALU_MOD : 5'd0;
        bus.mem_ready     = isMem;
        if (startInExec) begin
            bus.start      = 1'b1;
            bus.start_addr = 10'h155;
        end
        setExp(1'b0, 1'b0, 1'b0, cmt);
        nextCycle();
        bumpCount();
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;

        if (kind == K_HALT) begin
            mDone = 1'b1;
            return;
        end
        if (cmt) begin
            mPc = (kind == K_BRANCH && taken) ? target : (mPc + 1) % PC_MOD;
            return;
        end

        last = strobe ? nWait : TB_MAX - 1;
        for (int k = 0; k <= last; k++) begin
            if (k == resetAt) begin
                checkEn       = 1'b0;
                bus.mem_ready = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                checkReset("midRst");
                return;
            end
            hit = strobe && (k == nWait);
            bus.mem_ready = isMem && hit;
            bus.mod_done  = isMod && hit;
            setExp(1'b0, isMem, isMod && (k == 0), hit);
            nextCycle();
            bumpCount();
        end
        bus.mem_ready = 1'b0;
        bus.mod_done  = 1'b0;
        if (strobe) mPc = (mPc + 1) % PC_MOD;
        else        mFault = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the summary");
        $fatal(1, "[TB] time limit expired");
    end

    initial begin
        clearDecode();
        bus.start_addr = '0;
        #2;
        checkReset("rst");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        checkEn = 1'b1;
        idleCycle();

        // Three adds then halt from 0x010.
        commitSeen = 0;
        startProgram(10'h010);
        repeat (3) applyStimulus(K_ADD, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        applyStimulus(K_HALT, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        idleCycle();
        checkOutput("p1Pc",      32'(bus.pc),          32'h013);
        checkOutput("p1Done",    32'(bus.done),        32'h1);
        checkOutput("p1Count",   32'(bus.cycle_count), 32'd8);
        checkOutput("p1Commits", commitSeen,           32'd3);

        // Taken and not-taken branch at 0x020.
        startProgram(10'h020);
        applyStimulus(K_BRANCH, 1'b1, 10'h005, 0, 1'b1, 1'b0, -1);
        checkOutput("brTaken", 32'(bus.pc), 32'h005);
        applyStimulus(K_HALT, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        idleCycle();
        startProgram(10'h020);
        applyStimulus(K_BRANCH, 1'b0, 10'h005, 0, 1'b1, 1'b0, -1);
        checkOutput("brNotTaken", 32'(bus.pc), 32'h021);
        applyStimulus(K_HALT, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        idleCycle();

        // Load with three silent wait cycles, store hitting the watchdog limit, short MOD.
        startProgram(10'h030);
        commitSeen = 0;
        memReqSeen = 0;
        applyStimulus(K_LOAD, 1'b0, 0, 3, 1'b1, 1'b0, -1);
        checkOutput("ldMemReq",  memReqSeen,           32'd4);
        checkOutput("ldCommits", commitSeen,           32'd1);
        checkOutput("ldLatency", 32'(bus.cycle_count), 32'd6);
        checkOutput("ldPc",      32'(bus.pc),          32'h031);
        applyStimulus(K_STORE, 1'b0, 0, TB_MAX - 1, 1'b1, 1'b0, -1);
        checkOutput("stEdgeFault", 32'(bus.fault), 32'h0);
        checkOutput("stEdgePc",    32'(bus.pc),    32'h032);
        applyStimulus(K_MOD, 1'b0, 0, 2, 1'b1, 1'b0, -1);
        applyStimulus(K_HALT, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        idleCycle();

        // A MOD operation that never finishes faults, then START recovers.
        startProgram(10'h100);
        commitSeen = 0;
        applyStimulus(K_MOD, 1'b0, 0, 0, 1'b0, 1'b0, -1);
        idleCycle();
        checkOutput("toFault",   32'(bus.fault),       32'h1);
        checkOutput("toPc",      32'(bus.pc),          32'h100);
        checkOutput("toCommits", commitSeen,           32'd0);
        checkOutput("toCount",   32'(bus.cycle_count), 32'd66);
        startProgram(10'h200);
        checkOutput("rsFault", 32'(bus.fault), 32'h0);
        applyStimulus(K_ADD, 1'b0, 0, 0, 1'b1, 1'b1, -1);
        checkOutput("execStartPc", 32'(bus.pc), 32'h201);
        applyStimulus(K_HALT, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        idleCycle();

        // PC wrap from all-ones.
        startProgram(10'h3FF);
        applyStimulus(K_ADD, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        checkOutput("wrapPc",    32'(bus.pc),          32'h000);
        checkOutput("wrapCount", 32'(bus.cycle_count), 32'd2);
        applyStimulus(K_HALT, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        idleCycle();

        // Asynchronous reset in the middle of a memory wait.
        startProgram(10'h040);
        applyStimulus(K_LOAD, 1'b0, 0, 5, 1'b1, 1'b0, 2);
        nextCycle();
        clearDecode();
        rst_n  = 1'b1;
        mPc    = 0;
        mCount = 0;
        mDone  = 1'b0;
        mFault = 1'b0;
        checkEn = 1'b1;
        idleCycle();
        idleCycle();

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
